// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the PC, talks to the instruction bus over a req/ack handshake and
// drives the IF/ID register consumed by id_stage. Redirects from ID and the
// trap unit are applied here; a one-entry skid absorbs an instruction that
// returns while the pipeline is stalled.
module if_stage #(
   parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_stall,
   input  logic        mem_stall,
   input  logic        take_branch,
   input  logic [31:0] pc_branch_address,
   input  logic        jump_op,
   input  logic [31:0] pc_jump_address,
   input  logic        trap_valid,
   input  logic [31:0] trap_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        imem_err,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_add4,
   output logic [31:0] id_instruction,
   output logic        id_exc_address_if
);

   typedef enum logic [1:0] {
      FETCH    = 2'd0,
      ABORT    = 2'd1,
      HOLD     = 2'd2,
      MISALIGN = 2'd3
   } state_t;

   state_t      state_reg;
   logic [31:0] pc_reg;
   logic [31:0] target_reg;
   logic [31:0] skid_pc_reg;
   logic [31:0] skid_data_reg;
   logic        skid_err_reg;
   logic        exc_sent_reg;
   logic        req_en_reg;
   logic [31:0] id_pc_reg;
   logic [31:0] id_pc_add4_reg;
   logic [31:0] id_instr_reg;
   logic        id_exc_reg;

   logic        stall;
   logic        ack;
   logic        id_redirect;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] abort_target;
   logic [31:0] pc_add4;

   // Redirect decode: trap beats jump beats branch; ID redirects wait out stalls.
   always_comb begin
      stall           = id_stall | mem_stall;
      ack             = imem_req & imem_ack;
      id_redirect     = ~stall & (jump_op | take_branch);
      redirect        = trap_valid | id_redirect;
      redirect_target = pc_branch_address;
      if (trap_valid)
         redirect_target = trap_address;
      else if (jump_op)
         redirect_target = pc_jump_address;
      abort_target    = trap_valid ? trap_address : target_reg;
      pc_add4         = pc_reg + 32'd4;
   end

   // The request is suppressed for one cycle after reset and never issued
   // outside the two bus-owning states.
   assign imem_req          = req_en_reg & ((state_reg == FETCH) | (state_reg == ABORT));
   assign imem_addr         = {pc_reg[31:2], 2'b00};
   assign id_pc             = id_pc_reg;
   assign id_pc_add4        = id_pc_add4_reg;
   assign id_instruction    = id_instr_reg;
   assign id_exc_address_if = id_exc_reg;

   // Fetch FSM together with PC, skid and IF/ID register updates.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= FETCH;
         pc_reg         <= RESET_ADDR;
         target_reg     <= RESET_ADDR;
         skid_pc_reg    <= 32'd0;
         skid_data_reg  <= NOP_INSTR;
         skid_err_reg   <= 1'b0;
         exc_sent_reg   <= 1'b0;
         req_en_reg     <= 1'b0;
         id_pc_reg      <= 32'd0;
         id_pc_add4_reg <= 32'd0;
         id_instr_reg   <= NOP_INSTR;
         id_exc_reg     <= 1'b0;
      end else begin
         req_en_reg <= 1'b1;
         case (state_reg)
            FETCH: begin
               if (redirect) begin
                  // Wrong-path fetch: flush IF/ID, drop or wait out the response.
                  id_instr_reg <= NOP_INSTR;
                  id_exc_reg   <= 1'b0;
                  if (ack) begin
                     pc_reg       <= redirect_target;
                     exc_sent_reg <= 1'b0;
                     state_reg    <= (redirect_target[1:0] != 2'b00) ? MISALIGN : FETCH;
                  end else begin
                     target_reg <= redirect_target;
                     state_reg  <= ABORT;
                  end
               end else if (ack) begin
                  pc_reg <= pc_add4;
                  if (stall) begin
                     skid_pc_reg   <= pc_reg;
                     skid_data_reg <= imem_data;
                     skid_err_reg  <= imem_err;
                     state_reg     <= HOLD;
                  end else begin
                     id_pc_reg      <= pc_reg;
                     id_pc_add4_reg <= pc_add4;
                     id_instr_reg   <= imem_err ? NOP_INSTR : imem_data;
                     id_exc_reg     <= imem_err;
                  end
               end else if (!stall) begin
                  id_instr_reg <= NOP_INSTR;
                  id_exc_reg   <= 1'b0;
               end
            end

            ABORT: begin
               // Finish the abandoned request; a trap overrides the saved target.
               if (ack) begin
                  pc_reg       <= abort_target;
                  exc_sent_reg <= 1'b0;
                  state_reg    <= (abort_target[1:0] != 2'b00) ? MISALIGN : FETCH;
               end else if (trap_valid) begin
                  target_reg <= trap_address;
               end
               if (trap_valid || !stall) begin
                  id_instr_reg <= NOP_INSTR;
                  id_exc_reg   <= 1'b0;
               end
            end

            HOLD: begin
               if (redirect) begin
                  // Skid content is wrong-path once a redirect is accepted.
                  pc_reg       <= redirect_target;
                  exc_sent_reg <= 1'b0;
                  id_instr_reg <= NOP_INSTR;
                  id_exc_reg   <= 1'b0;
                  state_reg    <= (redirect_target[1:0] != 2'b00) ? MISALIGN : FETCH;
               end else if (!stall) begin
                  id_pc_reg      <= skid_pc_reg;
                  id_pc_add4_reg <= skid_pc_reg + 32'd4;
                  id_instr_reg   <= skid_err_reg ? NOP_INSTR : skid_data_reg;
                  id_exc_reg     <= skid_err_reg;
                  state_reg      <= FETCH;
               end
            end

            MISALIGN: begin
               // Report the bad PC to ID exactly once, then idle until a trap.
               if (trap_valid) begin
                  pc_reg       <= trap_address;
                  exc_sent_reg <= 1'b0;
                  id_instr_reg <= NOP_INSTR;
                  id_exc_reg   <= 1'b0;
                  state_reg    <= (trap_address[1:0] != 2'b00) ? MISALIGN : FETCH;
               end else if (!stall) begin
                  id_instr_reg <= NOP_INSTR;
                  if (!exc_sent_reg) begin
                     id_pc_reg      <= pc_reg;
                     id_pc_add4_reg <= pc_add4;
                     id_exc_reg     <= 1'b1;
                     exc_sent_reg   <= 1'b1;
                  end else begin
                     id_exc_reg <= 1'b0;
                  end
               end
            end

            default: state_reg <= FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: zero-wait fetch, delayed ack, abort on
// branch, stall with skid, misaligned jump, trap, PC wrap, bus error, and
// reset during an abort.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_stall, mem_stall;
   logic        take_branch, jump_op, trap_valid;
   logic [31:0] pc_branch_address, pc_jump_address, trap_address;
   logic        imem_req, imem_ack, imem_err;
   logic [31:0] imem_addr, imem_data;
   logic [31:0] id_pc, id_pc_add4, id_instruction;
   logic        id_exc_address_if;
   logic        ack_en, err_en;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Memory model: every word holds a value derived from its address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0003;
   endfunction

   assign imem_ack  = imem_req & ack_en;
   assign imem_data = mem_word(imem_addr);
   assign imem_err  = imem_ack & err_en;

   if_stage dut (
      .clk               (clk),
      .rst               (rst),
      .id_stall          (id_stall),
      .mem_stall         (mem_stall),
      .take_branch       (take_branch),
      .pc_branch_address (pc_branch_address),
      .jump_op           (jump_op),
      .pc_jump_address   (pc_jump_address),
      .trap_valid        (trap_valid),
      .trap_address      (trap_address),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_data         (imem_data),
      .imem_err          (imem_err),
      .id_pc             (id_pc),
      .id_pc_add4        (id_pc_add4),
      .id_instruction    (id_instruction),
      .id_exc_address_if (id_exc_address_if)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end else begin
         $display("ok   %s: %08h", tag, obs);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      ack_en = 1'b0; err_en = 1'b0;
      id_stall = 1'b0; mem_stall = 1'b0;
      take_branch = 1'b0; jump_op = 1'b0; trap_valid = 1'b0;
      pc_branch_address = 32'd0; pc_jump_address = 32'd0; trap_address = 32'd0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Reset, then run zero-wait fetches until id_pc = 4*(n-1), imem_addr = 4*n.
   task automatic boot(input int n);
      do_reset();
      ack_en = 1'b1;
      step();
      repeat (n) step();
   endtask

   initial begin
      // Reset state and zero-wait streaming
      do_reset();
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_instr", id_instruction, NOP);
      check("rst_pc", id_pc, 32'd0);
      check("rst_exc", {31'd0, id_exc_address_if}, 32'd0);
      ack_en = 1'b1;
      step();
      check("boot_req", {31'd0, imem_req}, 32'd1);
      check("boot_addr", imem_addr, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stream_pc", id_pc, 32'(4 * i));
         check("stream_instr", id_instruction, mem_word(32'(4 * i)));
      end
      check("stream_add4", id_pc_add4, 32'h10);

      // Ack delayed three cycles on 0x10
      check("wait_addr0", imem_addr, 32'h10);
      ack_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check("wait_bubble", id_instruction, NOP);
         check("wait_addr", imem_addr, 32'h10);
         check("wait_req", {31'd0, imem_req}, 32'd1);
      end
      ack_en = 1'b1;
      step();
      check("wait_pc", id_pc, 32'h10);
      check("wait_instr", id_instruction, mem_word(32'h10));

      // Branch to 0x40 while fetch of 0x0C is pending
      boot(3);
      check("br_addr0", imem_addr, 32'h0C);
      ack_en = 1'b0;
      take_branch = 1'b1; pc_branch_address = 32'h40;
      step();
      take_branch = 1'b0;
      check("br_flush", id_instruction, NOP);
      check("br_abort_addr", imem_addr, 32'h0C);
      step();
      check("br_abort_addr2", imem_addr, 32'h0C);
      check("br_bubble", id_instruction, NOP);
      ack_en = 1'b1;
      step();
      check("br_discard", id_instruction, NOP);
      check("br_new_addr", imem_addr, 32'h40);
      step();
      check("br_pc", id_pc, 32'h40);
      check("br_instr", id_instruction, mem_word(32'h40));

      // Reset pulse during ABORT
      boot(3);
      ack_en = 1'b0;
      take_branch = 1'b1; pc_branch_address = 32'h40;
      step();
      take_branch = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rabt_req", {31'd0, imem_req}, 32'd0);
      check("rabt_instr", id_instruction, NOP);
      check("rabt_addr", imem_addr, 32'd0);
      check("rabt_pc", id_pc, 32'd0);

      // Stall while ack for 0x20 arrives
      boot(8);
      check("st_addr0", imem_addr, 32'h20);
      id_stall = 1'b1;
      step();
      check("st_req", {31'd0, imem_req}, 32'd0);
      check("st_pc_hold", id_pc, 32'h1C);
      check("st_instr_hold", id_instruction, mem_word(32'h1C));
      id_stall = 1'b0; mem_stall = 1'b1;
      step();
      check("st_req2", {31'd0, imem_req}, 32'd0);
      check("st_pc_hold2", id_pc, 32'h1C);
      mem_stall = 1'b0;
      step();
      check("st_skid_pc", id_pc, 32'h20);
      check("st_skid_instr", id_instruction, mem_word(32'h20));
      check("st_resume_req", {31'd0, imem_req}, 32'd1);
      check("st_resume_addr", imem_addr, 32'h24);
      step();
      check("st_next_pc", id_pc, 32'h24);

      // Misaligned jump, trap recovery, PC wrap and bus error
      boot(1);
      jump_op = 1'b1; pc_jump_address = 32'h102;
      step();
      jump_op = 1'b0;
      check("mis_req", {31'd0, imem_req}, 32'd0);
      check("mis_flush", id_instruction, NOP);
      step();
      check("mis_pc", id_pc, 32'h102);
      check("mis_add4", id_pc_add4, 32'h106);
      check("mis_exc", {31'd0, id_exc_address_if}, 32'd1);
      check("mis_instr", id_instruction, NOP);
      step();
      check("mis_exc_once", {31'd0, id_exc_address_if}, 32'd0);
      check("mis_req2", {31'd0, imem_req}, 32'd0);
      trap_valid = 1'b1; trap_address = 32'h200;
      step();
      trap_valid = 1'b0;
      check("trap_req", {31'd0, imem_req}, 32'd1);
      check("trap_addr", imem_addr, 32'h200);
      step();
      check("trap_pc", id_pc, 32'h200);
      check("trap_instr", id_instruction, mem_word(32'h200));
      trap_valid = 1'b1; trap_address = 32'hFFFF_FFFC;
      step();
      trap_valid = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
      check("wrap_flush", id_instruction, NOP);
      step();
      check("wrap_pc", id_pc, 32'hFFFF_FFFC);
      check("wrap_add4", id_pc_add4, 32'd0);
      check("wrap_next_addr", imem_addr, 32'd0);
      err_en = 1'b1;
      step();
      err_en = 1'b0;
      check("err_pc", id_pc, 32'd0);
      check("err_instr", id_instruction, NOP);
      check("err_exc", {31'd0, id_exc_address_if}, 32'd1);
      step();
      check("err_cont_pc", id_pc, 32'd4);
      check("err_cont_instr", id_instruction, mem_word(32'd4));
      check("err_cont_exc", {31'd0, id_exc_address_if}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
